cfs_apb_master: RTL and testbench

//  APB initiator for the Aligner's register interface (CTRL/STATUS/IRQEN/IRQ).

---
 rtl/cfs_apb_pkg.sv | 21 ++
 rtl/cfs_apb_master.sv | 113 +++++++++++
 tb/tb_cfs_apb_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfs_apb_pkg.sv
// Shared types for the APB initiator that fronts the Aligner register port.
package cfs_apb_pkg;

  localparam int APB_DATA_WIDTH = 32;
  localparam int APB_ADDR_MAX   = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;

  // Address is carried at full width; the master keeps only APB_ADDR_WIDTH bits.
  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_MAX-1:0]   addr;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/cfs_apb_master.sv
// Single-beat APB initiator: valid/ready command in, SETUP+ACCESS on APB, valid/ready response out.
// Optional ACCESS wait-state timeout is enabled by defining CFS_APB_MASTER_TIMEOUT_EN.
module cfs_apb_master
  import cfs_apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic                      pslverr,
  input  logic [APB_DATA_WIDTH-1:0] prdata
);

  apb_mst_state_t state_q, state_d;
  apb_cmd_t       cmd;
  apb_rsp_t       rsp_q;
  logic           timeout;
  logic           acc_done;
  logic           unused_addr;

  assign cmd = '{write: cmd_write, addr: APB_ADDR_MAX'(cmd_addr), wdata: cmd_wdata};
  assign unused_addr = ^(cmd.addr >> APB_ADDR_WIDTH);

`ifdef CFS_APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Abort on the cycle that would be the TIMEOUT_CYCLES-th stalled ACCESS cycle.
  assign timeout = (state_q == ACCESS) && !pready && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                           to_cnt <= '0;
    else if (state_q == SETUP)              to_cnt <= '0;
    else if (state_q == ACCESS && !pready)  to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign acc_done = (state_q == ACCESS) && (pready || timeout);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (acc_done)  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
  end

  // APB and response outputs are all registered; they change only with the state.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          psel   <= 1'b1;
          pwrite <= cmd.write;
          paddr  <= cmd.addr[APB_ADDR_WIDTH-1:0] & ~APB_ADDR_WIDTH'(3);
          pwdata <= cmd.write ? cmd.wdata : '0;
        end
        SETUP: penable <= 1'b1;
        ACCESS: if (acc_done) begin
          psel        <= 1'b0;
          penable     <= 1'b0;
          rsp_valid   <= 1'b1;
          rsp_q.err   <= pready ? pslverr : 1'b1;
          rsp_q.rdata <= (pready && !pwrite && !pslverr) ? prdata : '0;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_cfs_apb_master.sv
// Directed bench: cfs_apb_master driving a small Aligner register-block model.
module tb_cfs_apb_master;

  localparam int AW = 16;

  logic          pclk, presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;

  int checks = 0;
  int failures = 0;

  cfs_apb_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Register block model: CTRL@0 (size in [2:0], size=0 write rejected after 2 waits),
  // STATUS@C read-only, IRQEN@F0, IRQ@F4; anything else errors. Errors return junk data.
  logic [31:0] ctrl, irqen, s_rdata;
  logic        s_err, hold_off;
  int          need_wait, wcnt, acc_cnt;

  always_comb begin
    s_err     = 1'b1;
    s_rdata   = 32'hDEAD_BEEF;
    need_wait = 0;
    if (pwrite) begin
      if (paddr == 16'h0000) begin
        need_wait = (pwdata[2:0] == 3'd0) ? 2 : 0;
        s_err     = (pwdata[2:0] == 3'd0);
      end else if (paddr == 16'h00F0) s_err = 1'b0;
    end else begin
      case (paddr)
        16'h0000: begin s_err = 1'b0; s_rdata = ctrl;  end
        16'h000C: begin s_err = 1'b0; s_rdata = 32'h0; end
        16'h00F0: begin s_err = 1'b0; s_rdata = irqen; end
        16'h00F4: begin s_err = 1'b0; s_rdata = 32'h0; end
        default: ;
      endcase
    end
    if (s_err) s_rdata = 32'hDEAD_BEEF;
  end

  assign pready  = psel && penable && !hold_off && (wcnt >= need_wait);
  assign pslverr = s_err;
  assign prdata  = s_rdata;

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ctrl  <= 32'h1;
      irqen <= 32'h1F;
      wcnt  <= 0;
    end else begin
      wcnt <= (psel && penable && !pready) ? wcnt + 1 : 0;
      if (pready && pwrite && !pslverr) begin
        if (paddr == 16'h0000) ctrl  <= pwdata;
        if (paddr == 16'h00F0) irqen <= pwdata;
      end
    end
  end

  always @(posedge pclk) if (psel && penable) acc_cnt <= acc_cnt + 1;

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 20) begin @(posedge pclk); #1; n++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_accept: cmd_ready=%0b required 1 within 20 cycles", cmd_ready);
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(posedge pclk); #1; lat++; end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_wait: rsp_valid=%0b required 1 within 50 cycles", rsp_valid);
    end
  endtask

  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    issue(w, a, d);
    wait_rsp(lat);
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: psel=%0b pen=%0b pwr=%0b paddr=%h pwdata=%h rv=%0b rd=%h re=%0b required all 0",
               psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err);
    end
    presetn = 1'b1;
    @(posedge pclk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready);
    end
  endtask

  task automatic test_ctrl_rw();
    logic [31:0] rd; logic er; int lat;
    xfer(1'b0, 16'h0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1 || er !== 1'b0 || lat != 3) begin
      failures++; $display("FAIL ctrl_reset_read: rdata=%h err=%0b lat=%0d required 00000001/0/3", rd, er, lat);
    end
    xfer(1'b1, 16'h0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 5) begin
      failures++; $display("FAIL ctrl_size0_write: err=%0b rdata=%h lat=%0d required 1/00000000/5", er, rd, lat);
    end
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rsp_handshake: rsp_valid=%0b cmd_ready=%0b required 0/1", rsp_valid, cmd_ready);
    end
    xfer(1'b0, 16'h0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1 || er !== 1'b0) begin
      failures++; $display("FAIL ctrl_unchanged: rdata=%h err=%0b required 00000001/0", rd, er);
    end
    xfer(1'b1, 16'h0000, 32'h2, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 3) begin
      failures++; $display("FAIL ctrl_write: err=%0b rdata=%h lat=%0d required 0/00000000/3", er, rd, lat);
    end
    xfer(1'b0, 16'h0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h2 || er !== 1'b0) begin
      failures++; $display("FAIL ctrl_readback: rdata=%h err=%0b required 00000002/0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 16'h000C, 32'h5, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL status_write: err=%0b rdata=%h required 1/00000000", er, rd);
    end
    xfer(1'b0, 16'h0004, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL unmapped_read: err=%0b rdata=%h required 1/00000000", er, rd);
    end
    xfer(1'b0, 16'h00F3, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h1F) begin
      failures++; $display("FAIL addr_align: err=%0b rdata=%h required 0/0000001F", er, rd);
    end
  endtask

  task automatic test_rsp_hold();
    int lat;
    issue(1'b0, 16'h00F0, 32'hFFFF_FFFF);
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 16'h00F0 || pwdata !== 32'h0) begin
      failures++; $display("FAIL setup_phase: psel=%0b pen=%0b pwr=%0b paddr=%h pwdata=%h required 1/0/0/00f0/00000000",
                           psel, penable, pwrite, paddr, pwdata);
    end
    @(posedge pclk); #1;
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 16'h00F0 || pwdata !== 32'h0) begin
      failures++; $display("FAIL access_phase: psel=%0b pen=%0b paddr=%h pwdata=%h required 1/1/00f0/00000000",
                           psel, penable, paddr, pwdata);
    end
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1F || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || psel !== 1'b0) begin
        failures++; $display("FAIL rsp_hold[%0d]: rv=%0b rd=%h re=%0b cr=%0b psel=%0b required 1/0000001f/0/0/0",
                             i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, psel);
      end
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rsp_release: rsp_valid=%0b cmd_ready=%0b required 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 16'h0000, 32'h0);
    @(posedge pclk); #1;
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      failures++; $display("FAIL mid_access: psel=%0b pen=%0b required 1/1", psel, penable);
    end
    #2 presetn = 1'b0;
    #1;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL async_reset: psel=%0b pen=%0b rv=%0b cr=%0b required 0/0/0/1",
                           psel, penable, rsp_valid, cmd_ready);
    end
    @(negedge pclk);
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(1'b0, 16'h0000, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1 || er !== 1'b0 || lat != 3) begin
      failures++; $display("FAIL post_reset_read: rdata=%h err=%0b lat=%0d required 00000001/0/3", rd, er, lat);
    end
  endtask

`ifdef CFS_APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic er; int lat;
    hold_off = 1'b1;
    acc_cnt  = 0;
    xfer(1'b0, 16'h0000, 32'h0, rd, er, lat);
    hold_off = 1'b0;
    checks++;
    if (acc_cnt != 4 || lat != 6) begin
      failures++; $display("FAIL timeout_len: access_cycles=%0d lat=%0d required 4/6", acc_cnt, lat);
    end
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL timeout_rsp: err=%0b rdata=%h required 1/00000000", er, rd);
    end
  endtask
`endif

  initial begin
    presetn = 1'b0; hold_off = 1'b0; acc_cnt = 0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    #12;
    test_reset();
    test_ctrl_rw();
    test_errors();
    test_rsp_hold();
    test_reset_mid();
`ifdef CFS_APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
